// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// mc_control_fsm : multicycle MIPS main controller (R, lw, sw, beq) with
//                  memory stall/timeout trap and retired-instruction counter
// Revision       : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             instr_done_o,
  output logic             illegal_op_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] c_OP_R   = 6'b000000;
  localparam logic [5:0] c_OP_LW  = 6'b100011;
  localparam logic [5:0] c_OP_SW  = 6'b101011;
  localparam logic [5:0] c_OP_BEQ = 6'b000100;
  localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;
  logic             mem_state, stalled, timeout_hit, instr_done;

  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; end
      S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b10;
        c.pc_source     = 2'b01;
        c.pc_write_cond = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    stalled     = mem_state && !mem_ready_i;
    // A completing access (mem_ready=1) never trips the timeout.
    timeout_hit = stalled && (c_TIMEOUT != 8'd0) && (wait_q == c_TIMEOUT);
    instr_done  = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEMWR) && mem_ready_i);

    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q | timeout_hit;

    if (timeout_hit) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
        S_DECODE: begin
          case (opcode_i)
            c_OP_R:           state_d = S_EXEC;
            c_OP_LW, c_OP_SW: state_d = S_MEMADR;
            c_OP_BEQ:         state_d = S_BRANCH;
            default: begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEMADR: state_d = (opcode_i == c_OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
        S_MEMWB:  state_d = S_FETCH;
        S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
        S_EXEC:   state_d = S_ALUWB;
        S_ALUWB:  state_d = S_FETCH;
        S_BRANCH: state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
    end

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (stalled) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end

    retired_d = retired_q + CNT_W'(instr_done);
  end

  // Moore controls are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_decode(S_FETCH);
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_decode(state_d);
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign pc_write_o      = (state_q == S_FETCH) && mem_ready_i;
  assign ir_write_o      = (state_q == S_FETCH) && mem_ready_i;
  assign pc_write_cond_o = ctrl_q.pc_write_cond;
  assign iord_o          = ctrl_q.iord;
  assign mem_read_o      = ctrl_q.mem_read;
  assign mem_write_o     = ctrl_q.mem_write;
  assign mem_to_reg_o    = ctrl_q.mem_to_reg;
  assign reg_write_o     = ctrl_q.reg_write;
  assign reg_dst_o       = ctrl_q.reg_dst;
  assign alu_src_a_o     = ctrl_q.alu_src_a;
  assign alu_src_b_o     = ctrl_q.alu_src_b;
  assign alu_op_o        = ctrl_q.alu_op;
  assign pc_source_o     = ctrl_q.pc_source;
  assign state_o         = state_q;
  assign instr_done_o    = instr_done;
  assign illegal_op_o    = illegal_q;
  assign mem_err_o       = mem_err_q;
  assign retired_o       = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// tb_mc_control_fsm: vector table, multi-cycle corner sequences and a randomized
// run checked against an instruction-path reference model.
module tb_mc_control_fsm;

  localparam int unsigned T  = 4;
  localparam int unsigned CW = 4;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic          clk, rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          instr_done, illegal_op, mem_err;
  logic [CW-1:0] retired;

  mc_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .iord_o(iord),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .state_o(state), .instr_done_o(instr_done),
    .illegal_op_o(illegal_op), .mem_err_o(mem_err), .retired_o(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_fail;

  // Expected controls per state: {pcw,pcwc,iord,mr,mw,irw,m2r,rw,rd,asa,srcb,aluop,pcsrc}
  logic [15:0] ctrl_tab [16];

  // Reference model: each instruction is a path of states after DECODE.
  int            m_state;
  int            m_path[$];
  int            m_stalls;
  logic          m_illegal, m_err;
  logic [CW-1:0] m_retired;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic       done;
    logic [3:0] ret;
  } vec_t;
  vec_t tv[$];

  logic [5:0] legal_ops [4];
  logic [5:0] rop;
  logic       rheavy, rrdy;

  function automatic logic [15:0] mk(input logic pcw, pcwc, io, mr, mw, irw, m2r, rw, rd, asa,
                                     input logic [1:0] b, op, ps);
    return {pcw, pcwc, io, mr, mw, irw, m2r, rw, rd, asa, b, op, ps};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_path    = '{1};
    m_stalls  = 0;
    m_illegal = 1'b0;
    m_err     = 1'b0;
    m_retired = '0;
  endtask

  function automatic logic m_done(input logic rdy);
    return (m_state == 4) || (m_state == 7) || (m_state == 8) || ((m_state == 5) && rdy);
  endfunction

  function automatic logic [31:0] exp_vec(input logic rdy);
    logic [15:0] c;
    c = ctrl_tab[m_state];
    if (m_state == 0 && rdy) begin
      c[15] = 1'b1;
      c[10] = 1'b1;
    end
    return 32'({4'(m_state), c, m_done(rdy), m_illegal, m_err});
  endfunction

  function automatic logic [31:0] act_vec();
    return 32'({state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done, illegal_op, mem_err});
  endfunction

  task automatic model_advance(input logic [5:0] op, input logic rdy);
    if (m_done(rdy)) m_retired = m_retired + 1'b1;
    if (m_state == 15) return;
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !rdy) begin
      if (T != 0 && m_stalls == int'(T)) begin
        m_state = 15;
        m_err   = 1'b1;
        m_path.delete();
      end else begin
        m_stalls++;
      end
      return;
    end
    m_stalls = 0;
    if (m_state == 1) begin
      if (op == OP_R)        m_path = '{6, 7};
      else if (op == OP_LW)  m_path = '{2, 3, 4};
      else if (op == OP_SW)  m_path = '{2, 5};
      else if (op == OP_BEQ) m_path = '{8};
      else begin
        m_path    = '{15};
        m_illegal = 1'b1;
      end
    end
    if (m_path.size() == 0) begin
      m_state = 0;
      m_path  = '{1};
    end else begin
      m_state = m_path.pop_front();
    end
  endtask

  task automatic sample(input logic [5:0] op, input logic rdy);
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    check("outputs", act_vec(), exp_vec(rdy));
    check("retired", 32'(retired), 32'(m_retired));
  endtask

  task automatic advance(input logic [5:0] op, input logic rdy);
    model_advance(op, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_illegal", 32'(illegal_op), 32'd0);
    check("arst_mem_err", 32'(mem_err), 32'd0);
    check("arst_retired", 32'(retired), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic done, input logic [3:0] ret);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.done = done; v.ret = ret;
    tv.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) ctrl_tab[i] = '0;
    ctrl_tab[0] = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
    ctrl_tab[1] = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
    ctrl_tab[2] = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    ctrl_tab[3] = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    ctrl_tab[4] = mk(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00);
    ctrl_tab[5] = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    ctrl_tab[6] = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b00);
    ctrl_tab[7] = mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
    ctrl_tab[8] = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b01);
    legal_ops[0] = OP_R; legal_ops[1] = OP_LW; legal_ops[2] = OP_SW; legal_ops[3] = OP_BEQ;

    // op, mem_ready, expected state, instr_done, retired
    add(OP_R,  1, 0, 0, 0); add(OP_R,  1, 1, 0, 0); add(OP_R,  1, 6, 0, 0); add(OP_R,  1, 7, 1, 0);
    add(OP_LW, 1, 0, 0, 1); add(OP_LW, 1, 1, 0, 1); add(OP_LW, 1, 2, 0, 1); add(OP_LW, 1, 3, 0, 1);
    add(OP_LW, 1, 4, 1, 1);
    add(OP_SW, 1, 0, 0, 2); add(OP_SW, 1, 1, 0, 2); add(OP_SW, 1, 2, 0, 2); add(OP_SW, 1, 5, 1, 2);
    add(OP_BEQ, 1, 0, 0, 3); add(OP_BEQ, 0, 1, 0, 3); add(OP_BEQ, 0, 8, 1, 3);
    add(OP_LW, 1, 0, 0, 4); add(OP_LW, 1, 1, 0, 4); add(OP_LW, 1, 2, 0, 4); add(OP_LW, 0, 3, 0, 4);
    add(OP_LW, 0, 3, 0, 4); add(OP_LW, 0, 3, 0, 4); add(OP_LW, 1, 3, 0, 4); add(OP_LW, 1, 4, 1, 4);
    add(OP_SW, 1, 0, 0, 5); add(OP_SW, 1, 1, 0, 5); add(OP_SW, 1, 2, 0, 5); add(OP_SW, 0, 5, 0, 5);
    add(OP_SW, 1, 5, 1, 5);
    add(OP_R,  0, 0, 0, 6); add(OP_R,  0, 0, 0, 6); add(OP_R,  1, 0, 0, 6); add(OP_R,  1, 1, 0, 6);
    add(OP_R,  1, 6, 0, 6); add(OP_R,  1, 7, 1, 6);
    add(OP_BAD, 1, 0, 0, 7); add(OP_BAD, 1, 1, 0, 7); add(OP_BAD, 1, 15, 0, 7); add(OP_BAD, 1, 15, 0, 7);

    rst_n     = 1'b1;
    opcode    = OP_R;
    mem_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_flags", 32'({illegal_op, mem_err}), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tv[i]) begin
      sample(tv[i].op, tv[i].rdy);
      check("tbl_state", 32'(state), 32'(tv[i].st));
      check("tbl_done", 32'(instr_done), 32'(tv[i].done));
      check("tbl_retired", 32'(retired), 32'(tv[i].ret));
      advance(tv[i].op, tv[i].rdy);
    end
    check("tbl_illegal", 32'(illegal_op), 32'd1);
    async_reset_check();

    // FETCH stall runs into the timeout after T+1 cycles
    for (int i = 0; i < 5; i++) begin
      sample(OP_R, 1'b0);
      check("to_fetch_state", 32'(state), 32'd0);
      check("to_fetch_err", 32'(mem_err), 32'd0);
      advance(OP_R, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      sample(OP_R, 1'b1);
      check("to_halt_state", 32'(state), 32'd15);
      check("to_halt_err", 32'(mem_err), 32'd1);
      check("to_halt_ctrl", 32'({mem_read, ir_write, pc_write}), 32'd0);
      advance(OP_R, 1'b1);
    end
    async_reset_check();

    // reset while stalled in MEMRD
    for (int i = 0; i < 3; i++) begin sample(OP_LW, 1'b1); advance(OP_LW, 1'b1); end
    for (int i = 0; i < 2; i++) begin sample(OP_LW, 1'b0); advance(OP_LW, 1'b0); end
    check("stall_state", 32'(state), 32'd3);
    async_reset_check();

    rop    = OP_R;
    rheavy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 15) begin
        async_reset_check();
      end else begin
        if (m_state == 0) begin
          if ($urandom_range(0, 19) == 0) rop = 6'($urandom);
          else rop = legal_ops[$urandom_range(0, 3)];
          rheavy = ($urandom_range(0, 5) == 0);
        end
        rrdy = rheavy ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
        sample(rop, rrdy);
        advance(rop, rrdy);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main controller for the MIPS datapath: sequences a shared instruction/data memory, IR, register file, ALU and PC over several cycles per instruction.
- Supports R-format, lw, sw and beq.
- Stalls on a memory ready handshake, traps illegal opcodes and memory timeouts, and counts retired instructions.
- Sits between the IR opcode field and the multicycle datapath mux/enable controls.

Parameters:
- MEM_TIMEOUT, 15, maximum stall cycles in one memory state before a trap; 0 disables the timeout (range 0..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  out  2  00 = add, 01 = R-format (funct decode), 10 = subtract.
- pc_source  out  2  00 = ALU result, 01 = ALUOut register.
- state  out  4  current state.
- instr_done  out  1  high in the last cycle of each instruction.
- illegal_op  out  1  sticky flag.
- mem_err  out  1  sticky flag.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, HALT=15. Codes 9..14 are unused and go to FETCH.
- Reset (asynchronous, active-low): state=FETCH, retired=0, illegal_op=0, mem_err=0, wait counter=0. Outputs then follow FETCH decode. The FSM restarts cleanly when reset is applied mid-instruction or during a stall.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100.
- Transitions:
  - FETCH to DECODE when mem_ready=1, else stay.
  - DECODE: R to EXEC; lw or sw to MEMADR; beq to BRANCH; any other opcode to HALT with illegal_op set.
  - MEMADR: lw to MEMRD; sw to MEMWR. The opcode is held stable by the IR.
  - MEMRD to MEMWB when mem_ready=1.
  - MEMWB to FETCH.
  - MEMWR to FETCH when mem_ready=1.
  - EXEC to ALUWB to FETCH.
  - BRANCH to FETCH.
  - HALT stays in HALT until reset.
- Output decode: every control is 0 unless listed for the state.
  - FETCH: mem_read=1, alu_src_b=01. ir_write and pc_write equal mem_ready (Mealy).
  - DECODE: alu_src_b=11.
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_read=1, iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - MEMWR: mem_write=1, iord=1.
  - EXEC: alu_src_a=1, alu_op=01.
  - ALUWB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_op=10, pc_source=01, pc_write_cond=1.
  - HALT: all controls 0.
- Memory handshake:
  - mem_read and mem_write stay asserted for the whole stall.
  - No register, IR or PC write occurs until the cycle in which mem_ready=1.
  - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Timeout:
  - An 8-bit wait counter increments on each cycle in FETCH, MEMRD or MEMWR with mem_ready=0.
  - It clears on any state change.
  - If MEM_TIMEOUT is nonzero and the counter equals MEM_TIMEOUT while mem_ready=0, the next state is HALT and mem_err is set.
  - If mem_ready=1 in that same cycle, the access completes normally and takes priority.
- instr_done is combinational. It is high in MEMWB, ALUWB and BRANCH, and in MEMWR when mem_ready=1.
- retired increments on each clock edge where instr_done=1 and wraps modulo 2^CNT_W.
- Latency with zero wait states: R=4, lw=5, sw=4, beq=3 cycles. Each stall cycle adds 1.

Test Plan:
- Release reset with mem_ready=1 and opcode=000000 -> states 0,1,6,7,0. reg_dst=1 and reg_write=1 in cycle 4 only. retired=1.
- opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0. mem_to_reg=1 only in state 4. Then opcode=101011 -> states 0,1,2,5,0 with mem_write=1, iord=1 in state 5. retired=2.
- opcode=000100 -> states 0,1,8. pc_write_cond=1, alu_op=10, pc_source=01 in state 8. The FSM returns to FETCH and instr_done pulses once.
- lw with mem_ready held 0 for 3 cycles in MEMRD -> FSM stays in state 3 with mem_read=1 and reg_write=0. Total latency is 8 cycles and no mem_err.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> HALT after 5 cycles in FETCH. mem_err=1, all controls 0. Only reset clears it.
- opcode=111111 -> DECODE to HALT, illegal_op=1, retired unchanged. Asserting rst_n=0 mid-stall -> state=0 and flags cleared immediately, without waiting for a clock edge.
